// File: rtl/bram_dp_simple_be.sv
// -----------------------------------------------------------------------------
// bram_dp_simple_be
//   Simple dual-port block RAM on a single clock. Port A writes with per-byte
//   enables, port B reads with a selectable 1- or 2-cycle latency and a
//   one-cycle valid pulse per accepted read. The behaviour of a same-address
//   read and write on one edge is set by RDW_MODE:
//   0 returns the old word, 1 returns the word as it looks after the write.
//
// Parameters
//   RAM_WIDTH      word width in bits (multiple of BYTE_WIDTH)
//   RAM_ADDR_BITS  address width, depth = 2**RAM_ADDR_BITS
//   BYTE_WIDTH     width of one write-enable lane
//   READ_LATENCY   1 or 2 cycles from read request to data_b_o
//   RDW_MODE       0 = read-old, 1 = write-first on a collision
//
// Ports
//   clk_i      clock, rising edge
//   arstn_i    asynchronous active-low reset (clears read pipeline only)
//   addr_a_i   write address
//   data_a_i   write data
//   we_a_i     write request
//   be_a_i     byte enables, bit k covers data bits [k*BYTE_WIDTH +: BYTE_WIDTH]
//   addr_b_i   read address
//   en_b_i     read request
//   data_b_o   read data, holds between reads
//   valid_b_o  one-cycle pulse marking new data on data_b_o
// -----------------------------------------------------------------------------
module bram_dp_simple_be #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0
) (
    input  logic                                clk_i,
    input  logic                                arstn_i,
    input  logic [RAM_ADDR_BITS-1:0]            addr_a_i,
    input  logic [RAM_WIDTH-1:0]                data_a_i,
    input  logic                                we_a_i,
    input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]     be_a_i,
    input  logic [RAM_ADDR_BITS-1:0]            addr_b_i,
    input  logic                                en_b_i,
    output logic [RAM_WIDTH-1:0]                data_b_o,
    output logic                                valid_b_o
);

    localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    // Elaboration-time parameter legality checks.
    if ((READ_LATENCY != 32'sd1) && (READ_LATENCY != 32'sd2)) begin : g_bad_latency
        $fatal(1, "bram_dp_simple_be: READ_LATENCY must be 1 or 2");
    end
    if ((RAM_WIDTH % BYTE_WIDTH) != 32'sd0) begin : g_bad_width
        $fatal(1, "bram_dp_simple_be: RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end

    // Overlay the enabled bytes of new_w onto old_w.
    function automatic logic [RAM_WIDTH-1:0] merge_bytes(
        input logic [RAM_WIDTH-1:0] old_w,
        input logic [RAM_WIDTH-1:0] new_w,
        input logic [NB-1:0]        be
    );
        logic [RAM_WIDTH-1:0] m;
        m = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                m[k*BYTE_WIDTH +: BYTE_WIDTH] = new_w[k*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                m[k*BYTE_WIDTH +: BYTE_WIDTH] = old_w[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return m;
    endfunction

    // Storage array: deliberately never reset so it maps onto a BRAM macro.
    logic [RAM_WIDTH-1:0] mem_q [DEPTH];

    logic                 collide_s;
    logic [RAM_WIDTH-1:0] rd_word_s;
    logic [RAM_WIDTH-1:0] s1_data_d;
    logic [RAM_WIDTH-1:0] s1_data_q;
    logic                 s1_valid_d;
    logic                 s1_valid_q;

    // Port A byte-lane write; gated by arstn_i so nothing lands during reset.
    always_ff @(posedge clk_i) begin
        if (we_a_i && arstn_i) begin
            for (int k = 0; k < NB; k++) begin
                if (be_a_i[k]) begin
                    mem_q[addr_a_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_a_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Port B read word, with write-first forwarding on a same-address collision.
    always_comb begin
        collide_s = we_a_i & en_b_i & (addr_a_i == addr_b_i);
        rd_word_s = mem_q[addr_b_i];
        if ((RDW_MODE == 32'sd1) && collide_s) begin
            rd_word_s = merge_bytes(mem_q[addr_b_i], data_a_i, be_a_i);
        end else begin
            rd_word_s = mem_q[addr_b_i];
        end
    end

    // Stage 1 next state: capture on a read, otherwise hold data and drop valid.
    always_comb begin
        s1_valid_d = en_b_i;
        s1_data_d  = s1_data_q;
        if (en_b_i) begin
            s1_data_d = rd_word_s;
        end else begin
            s1_data_d = s1_data_q;
        end
    end

    // Stage 1 registers (the BRAM's internal read register).
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    if (READ_LATENCY == 32'sd2) begin : g_lat2
        logic [RAM_WIDTH-1:0] s2_data_d;
        logic [RAM_WIDTH-1:0] s2_data_q;
        logic                 s2_valid_q;

        // Stage 2 next state: only advance data when stage 1 holds a fresh word.
        always_comb begin
            s2_data_d = s2_data_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
            end else begin
                s2_data_d = s2_data_q;
            end
        end

        // Stage 2 registers (the BRAM's optional output register).
        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_data_q  <= s2_data_d;
                s2_valid_q <= s1_valid_q;
            end
        end

        assign data_b_o  = s2_data_q;
        assign valid_b_o = s2_valid_q;
    end else begin : g_lat1
        assign data_b_o  = s1_data_q;
        assign valid_b_o = s1_valid_q;
    end

endmodule

// File: tb/tb_bram_dp_simple_be.sv
// -----------------------------------------------------------------------------
// tb_bram_dp_simple_be
//   Drives four instances of bram_dp_simple_be in parallel with identical
//   inputs: (latency 1, read-old), (latency 1, write-first),
//   (latency 2, read-old), (latency 2, write-first). A word-level reference
//   memory plus a short per-edge history of read results gives the expected
//   data_b_o / valid_b_o for every instance after every clock edge.
// -----------------------------------------------------------------------------
module tb_bram_dp_simple_be;

    logic        clk;
    logic        arstn;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic        we_a;
    logic [3:0]  be_a;
    logic [9:0]  addr_b;
    logic        en_b;
    logic [31:0] dout [4];
    logic        vld  [4];

    int n_tests;
    int n_fail;

    // Reference state
    logic [31:0] model_mem [1024];
    bit          cur_en, prev_en;
    logic [31:0] cur_val  [2];
    logic [31:0] prev_val [2];
    logic [31:0] exp_data [4];
    bit          exp_vld  [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bram_dp_simple_be #(
            .RAM_WIDTH    (32),
            .RAM_ADDR_BITS(10),
            .BYTE_WIDTH   (8),
            .READ_LATENCY (g / 2 + 1),
            .RDW_MODE     (g % 2)
        ) u_dut (
            .clk_i    (clk),
            .arstn_i  (arstn),
            .addr_a_i (addr_a),
            .data_a_i (data_a),
            .we_a_i   (we_a),
            .be_a_i   (be_a),
            .addr_b_i (addr_b),
            .en_b_i   (en_b),
            .data_b_o (dout[g]),
            .valid_b_o(vld[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur_en  = 1'b0;
        prev_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 32'h0;
            exp_vld[i]  = 1'b0;
        end
    endtask

    // Apply the rules of one clock edge to the reference.
    task automatic model_edge();
        logic [31:0] old_w, new_w;
        if (!arstn) begin
            model_clear();
        end else begin
            old_w = model_mem[addr_b];
            new_w = old_w;
            for (int k = 0; k < 4; k++) begin
                if (we_a && be_a[k] && (addr_a == addr_b)) new_w[k*8 +: 8] = data_a[k*8 +: 8];
            end
            prev_en     = cur_en;
            prev_val[0] = cur_val[0];
            prev_val[1] = cur_val[1];
            cur_en      = en_b;
            cur_val[0]  = old_w;
            cur_val[1]  = new_w;
            if (we_a) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_a[k]) model_mem[addr_a][k*8 +: 8] = data_a[k*8 +: 8];
                end
            end
            for (int i = 0; i < 4; i++) begin
                bit e;
                logic [31:0] v;
                e = (i < 2) ? cur_en : prev_en;
                v = (i < 2) ? cur_val[i % 2] : prev_val[i % 2];
                exp_vld[i] = e;
                if (e) exp_data[i] = v;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("cfg%0d valid", i), {31'h0, vld[i]}, {31'h0, exp_vld[i]});
            check_eq($sformatf("cfg%0d data", i), dout[i], exp_data[i]);
        end
    endtask

    // One cycle: drive at the negedge, model the posedge, check at the next negedge.
    task automatic step(input bit we, input logic [9:0] aa, input logic [31:0] da,
                        input logic [3:0] be, input bit en, input logic [9:0] ab);
        we_a   = we;
        addr_a = aa;
        data_a = da;
        be_a   = be;
        en_b   = en;
        addr_b = ab;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        arstn   = 1'b1;
        we_a    = 1'b0;
        en_b    = 1'b0;
        addr_a  = 10'h0;
        addr_b  = 10'h0;
        data_a  = 32'h0;
        be_a    = 4'h0;
        model_clear();
        #2 arstn = 1'b0;
        @(negedge clk);

        // Reset state: three cycles in reset, then idle cycles after release
        for (int c = 0; c < 3; c++) step(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);
        arstn = 1'b1;
        for (int c = 0; c < 3; c++) step(1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 10'h0);

        // Give every word a defined value
        for (int a = 0; a < 1024; a++) step(1'b1, a[9:0], $urandom, 4'hF, 1'b0, 10'h0);

        // Byte-enable write then read of address 5
        step(1'b1, 10'd5, 32'h11223344, 4'hF, 1'b0, 10'd0);
        step(1'b1, 10'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 10'd0);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
        check_eq("be lat1 data", dout[0], 32'h11BB33DD);
        check_eq("be lat1 valid", {31'h0, vld[0]}, 32'h1);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);
        check_eq("be lat2 data", dout[2], 32'h11BB33DD);
        check_eq("be lat1 pulse", {31'h0, vld[0]}, 32'h0);

        // Latency-2 streaming
        for (int a = 0; a < 4; a++) step(1'b1, a[9:0], 32'hA0 + a, 4'hF, 1'b0, 10'd0);
        for (int a = 0; a < 5; a++) begin
            step(1'b0, 10'd0, 32'h0, 4'h0, (a < 4), a[9:0]);
            if (a == 0) begin
                check_eq("stream lat2 early", {31'h0, vld[2]}, 32'h0);
            end else begin
                check_eq("stream lat2 valid", {31'h0, vld[2]}, 32'h1);
                check_eq("stream lat2 data", dout[2], 32'hA0 + a - 1);
            end
        end

        // Collision on address 7
        step(1'b1, 10'd7, 32'h0, 4'hF, 1'b0, 10'd0);
        step(1'b1, 10'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 10'd7);
        check_eq("rdw old", dout[0], 32'h00000000);
        check_eq("rdw first", dout[1], 32'h0000FFFF);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd7);
        check_eq("raw old mode", dout[0], 32'h0000FFFF);
        check_eq("raw first mode", dout[1], 32'h0000FFFF);
        check_eq("rdw lat2 old", dout[2], 32'h00000000);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);

        // Reset mid-read, with writes attempted during reset
        step(1'b1, 10'd9, 32'h12345678, 4'hF, 1'b0, 10'd0);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
        arstn = 1'b0;
        #1;
        model_clear();
        check_outputs();
        check_eq("midrst lat2 data", dout[2], 32'h0);
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 10'd9, 32'h5555AAAA, 4'hF, 1'b0, 10'd0);
            check_eq("midrst lat2 valid", {31'h0, vld[2]}, 32'h0);
        end
        arstn = 1'b1;
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd9);
        check_eq("wr in reset", dout[0], 32'h12345678);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5);
        check_eq("mem kept", dout[0], 32'h11BB33DD);
        step(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0);

        // Randomized traffic with frequent same-address collisions
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] aa, ab;
            aa = 10'($urandom_range(0, 1023));
            ab = ($urandom_range(0, 3) == 0) ? aa : 10'($urandom_range(0, 1023));
            step(1'($urandom_range(0, 1)), aa, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_dp_simple_be.md
# bram_dp_simple_be

Simple dual-port block RAM on one clock: port A writes, port B reads. It extends the basic simple dual-port BRAM with four additions: per-byte write enables, a selectable read latency of 1 or 2 cycles, a read-data valid flag, and a configurable read-during-write collision mode. It is the memory primitive behind frame buffers and packet stores in the lab designs, and it must infer to a single BRAM macro with its optional output register.

## Interface
- RAM_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- RAM_ADDR_BITS, 10, address width; depth = 2**RAM_ADDR_BITS
- BYTE_WIDTH, 8, width of one write-enable lane; NB = RAM_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, cycles from a sampled read request to data on data_b_o; legal values are 1 and 2
- RDW_MODE, 0, same-address collision behaviour: 0 = read-old, 1 = write-first (forward the new data)

Ports:
- clk_i  input  1  clock; all logic on the rising edge
- arstn_i  input  1  asynchronous, active-low reset
- addr_a_i  input  RAM_ADDR_BITS  write address
- data_a_i  input  RAM_WIDTH  write data
- we_a_i  input  1  write request
- be_a_i  input  NB  byte enables; bit k selects data bits [k*BYTE_WIDTH +: BYTE_WIDTH]
- addr_b_i  input  RAM_ADDR_BITS  read address
- en_b_i  input  1  read request
- data_b_o  output  RAM_WIDTH  read data
- valid_b_o  output  1  one-cycle pulse marking new data on data_b_o

## Operation
- **Write.** On an edge where we_a_i=1 and arstn_i=1, each byte k with be_a_i[k]=1 is written to mem[addr_a_i]. Bytes with be_a_i[k]=0 keep their old value. we_a_i=1 with be_a_i=0 changes nothing.
- **Writes during reset.** Writes are suppressed while arstn_i=0.
- **Memory is not reset.** The array is never reset and its initial contents are undefined. Reset clears only the output and pipeline registers.
- **Read, stage 1.** On an edge where en_b_i=1, stage 1 captures the word at mem[addr_b_i] and sets its valid bit. When en_b_i=0, the stage 1 data register holds and its valid bit clears.
- **Read, READ_LATENCY=1.** data_b_o and valid_b_o come straight from stage 1.
- **Read, READ_LATENCY=2.** A second register stage loads stage 1 data only when stage 1 valid=1. Its valid bit copies stage 1 valid every cycle. data_b_o and valid_b_o come from stage 2.
- **Hold.** data_b_o holds its last value between reads. Back-to-back reads, one per cycle, are fully supported.
- **Collision (same edge, we_a_i=1, en_b_i=1, addr_a_i==addr_b_i):**
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns a merged word. Bytes with be_a_i[k]=1 come from data_a_i; all other bytes are the old word.
- **No collision.** Different addresses, or only one port active: the ports are independent.
- **Read-after-write.** A read issued on the edge after a write to the same address always returns the new data, in both modes.
- **Illegal parameters.** An illegal READ_LATENCY value, or a RAM_WIDTH that is not a multiple of BYTE_WIDTH, is a fatal elaboration error (generate-time check).

## Timing
- **Reset values.** data_b_o=0, valid_b_o=0, and every pipeline valid bit is 0.
- **Reset assertion.** Asserting arstn_i clears all output and pipeline registers immediately (asynchronously). In-flight reads are discarded and produce no valid_b_o.
- **Reset release.** The first edge with arstn_i=1 may accept a read and a write.
- **Latency.** A read sampled at edge N drives data_b_o and valid_b_o=1 during the cycle after edge N+READ_LATENCY-1.
  - READ_LATENCY=1: valid after edge N.
  - READ_LATENCY=2: valid after edge N+1.
- **Throughput.** One read and one write per cycle, with no stalls and no backpressure.
- **Pulse width.** valid_b_o is high for exactly one cycle per accepted read.

## Test plan
- **Reset state.** Hold arstn_i=0 for 3 cycles, then release -> data_b_o=0 and valid_b_o=0 throughout, and until the first read.
- **Byte-enable write.** Defaults (RAM_WIDTH=32, NB=4), READ_LATENCY=1:
  - write 0x11223344 to address 5 with be=4'hF, then write 0xAABBCCDD to address 5 with be=4'b0101;
  - read address 5 -> 0x11BB33DD with valid_b_o=1 one cycle after the read edge.
- **Latency 2, streaming.** Fill addresses 0..3 with 0xA0..0xA3, then assert en_b_i on 4 consecutive edges for addresses 0..3 -> valid_b_o high for 4 consecutive cycles starting 2 cycles after the first read edge; data_b_o = 0xA0, 0xA1, 0xA2, 0xA3.
- **Collision.** Address 7 holds 0x00000000. On the same edge, write 0xFFFFFFFF with be=4'b0011 and read address 7:
  - RDW_MODE=0 -> read returns 0x00000000;
  - RDW_MODE=1 -> read returns 0x0000FFFF;
  - a read of address 7 on the next edge returns 0x0000FFFF in both modes.
- **Reset mid-read.** READ_LATENCY=2: issue a read, assert arstn_i 1 cycle later -> no valid_b_o pulse, data_b_o=0. Memory contents written before the reset read back unchanged afterward.
- **Write during reset.** Hold arstn_i=0 with we_a_i=1 writing 0x5555AAAA to address 9, which holds 0x12345678 -> after release, address 9 reads 0x12345678.
